// File: rtl/ide_ctrl_pkg.sv
// ide_ctrl_pkg: shared types and constants for the Zorro II IDE cycle controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package ide_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_ROMRD,
        ST_ACK
    } state_t;

    // Address bits inside the 64 KB board window
    localparam int          SEL_BIT  = 15;      // 0 = boot ROM, 1 = IDE
    localparam int          PORT_BIT = 14;      // 0 = IDE1, 1 = IDE2
    localparam int          CS_BIT   = 13;      // 0 = CS0 command, 1 = CS1 control
    localparam logic [2:0]  BANK_TAG = 3'b111;  // ADDR[14:12] of the ROM bank latch

    // Default timing in CLK7M cycles (141 ns each)
    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;
    localparam int DEF_ROM_WAIT      = 1;

    // Counter reload value for a phase lasting 'cycles' clocks
    function automatic logic [1:0] cnt_load(input int cycles);
        return 2'(cycles - 1);
    endfunction

endpackage

// File: rtl/ide_wait_counter.sv
// ide_wait_counter: 2-bit loadable down-counter with zero flag, paces FSM phases.
// Latency: count/zero are registered; a load is visible one edge later.
// Backpressure: none; holds at zero until reloaded.
// Ports: CLK7M, RESET (sync, active-low), load/load_val in; cnt, zero out.
module ide_wait_counter (
    input  logic       CLK7M,
    input  logic       RESET,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] cnt,
    output logic       zero
);
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge CLK7M) begin
        if (!RESET) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/ide_ctrl.sv
// ide_ctrl: Zorro II IDE/boot-ROM cycle controller, PIO mode 0 CS/IOR/IOW timing.
// Latency: CS on start edge, strobe after SETUP_CYCLES, DTACK in last strobe cycle.
// Backpressure: host holds AS_n until DTACK; next cycle waits for ACK->IDLE.
// Ports: CLK7M/RESET; 68000 ADDR/AS_n/UDS_n/LDS_n/RW/DIN; ide_access/ide_enable
//        from autoconfig; AS_n_S4, DTACK, IOR_n/IOW_n, IDEx_CS_n, IDE_ROMEN, ROM_BANK.
module ide_ctrl
    import ide_ctrl_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int ROM_WAIT      = DEF_ROM_WAIT
) (
    input  logic        CLK7M,
    input  logic        RESET,
    input  logic [23:1] ADDR,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        RW,
    input  logic [1:0]  DIN,
    input  logic        ide_access,
    input  logic        ide_enable,
    output logic        AS_n_S4,
    output logic        DTACK,
    output logic        IOR_n,
    output logic        IOW_n,
    output logic [1:0]  IDE1_CS_n,
    output logic [1:0]  IDE2_CS_n,
    output logic        IDE_ROMEN,
    output logic [1:0]  ROM_BANK
);
    state_t     state_q, state_d;
    logic       as_s4_q, as_s4_d;
    logic       dtack_q, dtack_d;
    logic       ior_q, ior_d;
    logic       iow_q, iow_d;
    logic [1:0] ide1_cs_q, ide1_cs_d;
    logic [1:0] ide2_cs_q, ide2_cs_d;
    logic       romen_q, romen_d;
    logic [1:0] bank_q, bank_d;
    logic       rw_q, rw_d;

    logic       cnt_load_en;
    logic [1:0] cnt_load_val;
    logic [1:0] cnt;
    logic       cnt_zero;
    logic       start;

    // Address bits outside the decoded fields are qualified by ide_access upstream
    logic unused_addr;
    assign unused_addr = ^{ADDR[23:16], ADDR[11:1]};

    assign start = !as_s4_q && ide_access && ide_enable && (!UDS_n || !LDS_n);

    always_comb begin
        state_d      = state_q;
        as_s4_d      = AS_n;
        dtack_d      = dtack_q;
        ior_d        = ior_q;
        iow_d        = iow_q;
        ide1_cs_d    = ide1_cs_q;
        ide2_cs_d    = ide2_cs_q;
        romen_d      = romen_q;
        bank_d       = bank_q;
        rw_d         = rw_q;
        cnt_load_val = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rw_d = RW;
                    if (ADDR[SEL_BIT]) begin
                        state_d      = ST_SETUP;
                        cnt_load_val = cnt_load(SETUP_CYCLES);
                        case ({ADDR[PORT_BIT], ADDR[CS_BIT]})
                            2'b00:   ide1_cs_d = 2'b10;
                            2'b01:   ide1_cs_d = 2'b01;
                            2'b10:   ide2_cs_d = 2'b10;
                            default: ide2_cs_d = 2'b01;
                        endcase
                    end else if (RW) begin
                        state_d      = ST_ROMRD;
                        romen_d      = 1'b1;
                        cnt_load_val = cnt_load(ROM_WAIT);
                    end else begin
                        // ROM-region writes are acknowledged; only the tag address latches
                        state_d = ST_ACK;
                        dtack_d = 1'b1;
                        if (ADDR[14:12] == BANK_TAG) begin
                            bank_d = DIN;
                        end
                    end
                end
            end

            ST_SETUP: begin
                if (as_s4_q) begin
                    // Aborted before the strobe: still give CS its full hold
                    state_d      = ST_HOLD;
                    dtack_d      = 1'b0;
                    cnt_load_val = cnt_load(HOLD_CYCLES);
                end else if (cnt_zero) begin
                    state_d      = ST_STROBE;
                    cnt_load_val = cnt_load(STROBE_CYCLES);
                    if (rw_q) begin
                        ior_d = 1'b0;
                    end else begin
                        iow_d = 1'b0;
                    end
                    // A one-cycle strobe is its own last cycle
                    if (STROBE_CYCLES == 1) begin
                        dtack_d = 1'b1;
                    end
                end
            end

            ST_STROBE: begin
                if (as_s4_q || cnt_zero) begin
                    state_d      = ST_HOLD;
                    ior_d        = 1'b1;
                    iow_d        = 1'b1;
                    cnt_load_val = cnt_load(HOLD_CYCLES);
                    if (as_s4_q) begin
                        dtack_d = 1'b0;
                    end
                end else if (cnt == 2'd1) begin
                    // Next cycle is the last strobe cycle
                    dtack_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d   = ST_ACK;
                    ide1_cs_d = 2'b11;
                    ide2_cs_d = 2'b11;
                end
            end

            ST_ROMRD: begin
                if (as_s4_q) begin
                    state_d = ST_IDLE;
                    romen_d = 1'b0;
                    dtack_d = 1'b0;
                end else if (cnt_zero) begin
                    state_d = ST_ACK;
                    dtack_d = 1'b1;
                end
            end

            ST_ACK: begin
                // DTACK keeps whatever it had: high normally, low after an abort
                if (as_s4_q) begin
                    state_d = ST_IDLE;
                    dtack_d = 1'b0;
                    romen_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                dtack_d   = 1'b0;
                ior_d     = 1'b1;
                iow_d     = 1'b1;
                ide1_cs_d = 2'b11;
                ide2_cs_d = 2'b11;
                romen_d   = 1'b0;
            end
        endcase
    end

    // Every state entry reloads the shared counter
    assign cnt_load_en = (state_d != state_q);

    always_ff @(posedge CLK7M) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            as_s4_q   <= 1'b1;
            dtack_q   <= 1'b0;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            ide1_cs_q <= 2'b11;
            ide2_cs_q <= 2'b11;
            romen_q   <= 1'b0;
            bank_q    <= 2'b00;
            rw_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            as_s4_q   <= as_s4_d;
            dtack_q   <= dtack_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            ide1_cs_q <= ide1_cs_d;
            ide2_cs_q <= ide2_cs_d;
            romen_q   <= romen_d;
            bank_q    <= bank_d;
            rw_q      <= rw_d;
        end
    end

    ide_wait_counter u_wait (
        .CLK7M    (CLK7M),
        .RESET    (RESET),
        .load     (cnt_load_en),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign AS_n_S4   = as_s4_q;
    assign DTACK     = dtack_q;
    assign IOR_n     = ior_q;
    assign IOW_n     = iow_q;
    assign IDE1_CS_n = ide1_cs_q;
    assign IDE2_CS_n = ide2_cs_q;
    assign IDE_ROMEN = romen_q;
    assign ROM_BANK  = bank_q;

endmodule

// File: tb/tb_ide_ctrl.sv
// tb_ide_ctrl: cycle-trace bench for ide_ctrl with default timing parameters.
// Latency: inputs driven on falling edge, outputs compared on the following falling edge.
// Backpressure: n/a.
module tb_ide_ctrl;

    logic        CLK7M = 1'b0;
    logic        RESET;
    logic [23:1] ADDR;
    logic        AS_n, UDS_n, LDS_n, RW;
    logic [1:0]  DIN;
    logic        ide_access, ide_enable;
    logic        AS_n_S4, DTACK, IOR_n, IOW_n, IDE_ROMEN;
    logic [1:0]  IDE1_CS_n, IDE2_CS_n, ROM_BANK;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK7M = ~CLK7M;

    ide_ctrl dut (
        .CLK7M      (CLK7M),
        .RESET      (RESET),
        .ADDR       (ADDR),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .LDS_n      (LDS_n),
        .RW         (RW),
        .DIN        (DIN),
        .ide_access (ide_access),
        .ide_enable (ide_enable),
        .AS_n_S4    (AS_n_S4),
        .DTACK      (DTACK),
        .IOR_n      (IOR_n),
        .IOW_n      (IOW_n),
        .IDE1_CS_n  (IDE1_CS_n),
        .IDE2_CS_n  (IDE2_CS_n),
        .IDE_ROMEN  (IDE_ROMEN),
        .ROM_BANK   (ROM_BANK)
    );

    // Expected output word: {AS_n_S4, DTACK, IOR_n, IOW_n, IDE1_CS_n, IDE2_CS_n, IDE_ROMEN, ROM_BANK}
    typedef struct {
        logic        rst_n;
        logic        as_n;
        logic        uds_n;
        logic        lds_n;
        logic        rw;
        logic        en;
        logic [15:0] a;
        logic [1:0]  din;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic as_n, input logic u, input logic l,
                                input logic w, input logic e, input logic [15:0] a,
                                input logic [1:0] d, input logic [10:0] x);
        vec_t v;
        v.rst_n = r; v.as_n = as_n; v.uds_n = u; v.lds_n = l;
        v.rw = w; v.en = e; v.a = a; v.din = d; v.exp = x;
        return v;
    endfunction

    // Drive inputs at a falling edge, let one rising edge pass, land on the next falling edge
    task automatic step(input logic r, input logic as_n, input logic u, input logic l,
                        input logic w, input logic e, input logic [15:0] a, input logic [1:0] d);
        RESET      = r;
        AS_n       = as_n;
        UDS_n      = u;
        LDS_n      = l;
        RW         = w;
        ide_enable = e;
        ide_access = 1'b1;
        ADDR       = {8'h00, a[15:1]};
        DIN        = d;
        @(posedge CLK7M);
        @(negedge CLK7M);
    endtask

    task automatic chk(input string nm, input logic [10:0] exp);
        logic [10:0] got;
        got = {AS_n_S4, DTACK, IOR_n, IOW_n, IDE1_CS_n, IDE2_CS_n, IDE_ROMEN, ROM_BANK};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got as_s4/dtack/ior/iow/cs1/cs2/romen/bank=%b expected %b", nm, got, exp);
        end
    endtask

    initial begin
        // Reset held with a live IDE read on the bus
        repeat (3) vecs.push_back(mk(0, 0,0,1,1,1, 16'h8000, 2'b00, 11'b1_0_1_1_11_11_0_00));
        // IDE1 CS0 read
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_0_1_1_11_11_0_00));
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_0_1_1_10_11_0_00));
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_0_0_1_10_11_0_00));
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_1_0_1_10_11_0_00));
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_1_1_1_10_11_0_00));
        vecs.push_back(mk(1, 0,0,1,1,1, 16'h8000, 2'b00, 11'b0_1_1_1_11_11_0_00));
        vecs.push_back(mk(1, 1,0,1,1,1, 16'h8000, 2'b00, 11'b1_1_1_1_11_11_0_00));
        vecs.push_back(mk(1, 1,0,1,1,1, 16'h8000, 2'b00, 11'b1_0_1_1_11_11_0_00));
        // IDE2 CS1 write, LDS_n only
        vecs.push_back(mk(1, 0,1,0,0,1, 16'hE000, 2'b00, 11'b0_0_1_1_11_11_0_00));
        vecs.push_back(mk(1, 0,1,0,0,1, 16'hE000, 2'b00, 11'b0_0_1_1_11_01_0_00));
        vecs.push_back(mk(1, 0,1,0,0,1, 16'hE000, 2'b00, 11'b0_0_1_0_11_01_0_00));
        vecs.push_back(mk(1, 0,1,0,0,1, 16'hE000, 2'b00, 11'b0_1_1_0_11_01_0_00));
        vecs.push_back(mk(1, 0,1,0,0,1, 16'hE000, 2'b00, 11'b0_1_1_1_11_01_0_00));
        vecs.push_back(mk(1, 1,1,0,0,1, 16'hE000, 2'b00, 11'b1_1_1_1_11_11_0_00));
        vecs.push_back(mk(1, 1,1,0,0,1, 16'hE000, 2'b00, 11'b1_0_1_1_11_11_0_00));
        // ROM bank latch write, DIN=10
        vecs.push_back(mk(1, 0,0,0,0,1, 16'h7000, 2'b10, 11'b0_0_1_1_11_11_0_00));
        vecs.push_back(mk(1, 0,0,0,0,1, 16'h7000, 2'b10, 11'b0_1_1_1_11_11_0_10));
        vecs.push_back(mk(1, 1,0,0,0,1, 16'h7000, 2'b10, 11'b1_1_1_1_11_11_0_10));
        vecs.push_back(mk(1, 1,0,0,0,1, 16'h7000, 2'b10, 11'b1_0_1_1_11_11_0_10));
        // ROM read
        vecs.push_back(mk(1, 0,0,0,1,1, 16'h0100, 2'b00, 11'b0_0_1_1_11_11_0_10));
        vecs.push_back(mk(1, 0,0,0,1,1, 16'h0100, 2'b00, 11'b0_0_1_1_11_11_1_10));
        vecs.push_back(mk(1, 1,0,0,1,1, 16'h0100, 2'b00, 11'b1_1_1_1_11_11_1_10));
        vecs.push_back(mk(1, 1,0,0,1,1, 16'h0100, 2'b00, 11'b1_0_1_1_11_11_0_10));

        RESET = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        DIN = 2'b00; ide_access = 1'b0; ide_enable = 1'b1; ADDR = '0;
        @(negedge CLK7M);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].as_n, vecs[i].uds_n, vecs[i].lds_n,
                 vecs[i].rw, vecs[i].en, vecs[i].a, vecs[i].din);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Abort: AS_n_S4 already high during the first STROBE cycle of an IDE1 write
        step(1, 0,0,1,0,1, 16'h8000, 2'b00); chk("abort_sync",   11'b0_0_1_1_11_11_0_10);
        step(1, 0,0,1,0,1, 16'h8000, 2'b00); chk("abort_cs",     11'b0_0_1_1_10_11_0_10);
        step(1, 1,0,1,0,1, 16'h8000, 2'b00); chk("abort_strobe", 11'b1_0_1_0_10_11_0_10);
        step(1, 1,0,1,0,1, 16'h8000, 2'b00); chk("abort_neg",    11'b1_0_1_1_10_11_0_10);
        step(1, 1,0,1,0,1, 16'h8000, 2'b00); chk("abort_hold",   11'b1_0_1_1_11_11_0_10);
        step(1, 1,0,1,0,1, 16'h8000, 2'b00); chk("abort_idle",   11'b1_0_1_1_11_11_0_10);

        // IDE disabled: a read sits on the bus, nothing may move, bank retained
        for (int k = 0; k < 6; k++) begin
            step(1, 0,0,1,1,0, 16'h8000, 2'b00);
            chk($sformatf("disabled%0d", k), 11'b0_0_1_1_11_11_0_10);
        end
        step(1, 1,0,1,1,0, 16'h8000, 2'b00); chk("disabled_rel", 11'b1_0_1_1_11_11_0_10);

        // Reset while IOR_n is low: everything returns to reset values on that edge
        step(1, 0,0,1,1,1, 16'h8000, 2'b00); chk("mrst_sync",   11'b0_0_1_1_11_11_0_10);
        step(1, 0,0,1,1,1, 16'h8000, 2'b00); chk("mrst_cs",     11'b0_0_1_1_10_11_0_10);
        step(1, 0,0,1,1,1, 16'h8000, 2'b00); chk("mrst_strobe", 11'b0_0_0_1_10_11_0_10);
        step(0, 0,0,1,1,1, 16'h8000, 2'b00); chk("mrst_reset",  11'b1_0_1_1_11_11_0_00);
        step(1, 1,0,1,1,1, 16'h8000, 2'b00); chk("mrst_after",  11'b1_0_1_1_11_11_0_00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ide_ctrl.md
# ide_ctrl

Amiga Zorro II IDE cycle controller for the RIPPLE board. It consumes the decoded `ide_access` window from autoconfig and the 68000 bus strobes. It produces:
- ATA PIO-mode-0-compliant chip selects and IOR/IOW strobes for two IDE ports;
- boot-ROM enable and bank select;
- the cycle-acknowledge pulse.

It sits between the autoconfig decoder and the IDE connectors/buffers, clocked by the 7.09 MHz CLK7M derived from C1n/C3n.

## Interface
Parameters:
- `SETUP_CYCLES`, 1: CLK7M cycles of CS-to-strobe setup (≥70 ns).
- `STROBE_CYCLES`, 2: CLK7M cycles IOR_n/IOW_n held low (≥165 ns).
- `HOLD_CYCLES`, 1: cycles CS held after strobe negation.
- `ROM_WAIT`, 1: cycles from ROM-cycle start to DTACK.

Ports:
- `CLK7M`  in  1  7.09 MHz bus clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `ADDR`  in  23  68000 address [23:1].
- `AS_n`  in  1  address strobe.
- `UDS_n`, `LDS_n`  in  1 each  data strobes.
- `RW`  in  1  1 = read.
- `DIN`  in  2  DBUS[15:14], ROM bank write data.
- `ide_access`  in  1  board window hit from autoconfig.
- `ide_enable`  in  1  IDE function enabled (latched by top during reset).
- `AS_n_S4`  out  1  AS_n registered on CLK7M.
- `DTACK`  out  1  cycle acknowledge, active-high.
- `IOR_n`, `IOW_n`  out  1 each  ATA read/write strobes.
- `IDE1_CS_n`, `IDE2_CS_n`  out  2 each  ATA CS0/CS1 per port.
- `IDE_ROMEN`  out  1  boot-ROM output enable.
- `ROM_BANK`  out  2  ROM bank select.

## Operation
Address map inside the 64 KB window:
- ADDR[15]=0: ROM region.
- ADDR[15]=1: IDE region.
  - ADDR[14]: port select, 0 = IDE1, 1 = IDE2.
  - ADDR[13]: 0 = CS0 (command block), 1 = CS1 (control block).
- Bank latch: write in ROM region with ADDR[14:12]=3'b111.

Cycle start condition, evaluated in IDLE:
- `AS_n_S4`=0, `ide_access`=1, `ide_enable`=1, and (UDS_n=0 or LDS_n=0).

State machine:
- IDLE
  - IDE region → SETUP. Selected CS_n goes low on the transition edge.
  - ROM read → ROMRD. IDE_ROMEN goes high.
  - Bank write → ACK. ROM_BANK <= DIN on the same edge.
  - ROM-region write not matching the bank address → ACK, no side effect.
- SETUP, `SETUP_CYCLES` cycles → STROBE. On entry, IOR_n (RW=1) or IOW_n (RW=0) goes low.
- STROBE, `STROBE_CYCLES` cycles → HOLD. DTACK goes high in the last STROBE cycle. The strobe is negated on the exit edge.
- HOLD, `HOLD_CYCLES` cycles → ACK. CS_n goes high on the exit edge.
- ROMRD, `ROM_WAIT` cycles → ACK. DTACK high on exit.
- ACK: DTACK held high.
  - When `AS_n_S4`=1: → IDLE; DTACK=0, IDE_ROMEN=0.

Other rules:
- Counter: one shared down-counter, loaded on each state entry with (param−1); advance when it reaches 0.
- Abort (AS_n_S4 rises in SETUP, STROBE or ROMRD, e.g. after BERR):
  - Strobe negated on the next edge.
  - IDE states go to HOLD (full CS hold still honoured); ROMRD goes to IDLE.
  - DTACK forced 0.
- `ide_enable`=0: no cycle ever starts; all outputs stay at reset values. ROM_BANK is retained.
- Only one of IOR_n/IOW_n is ever low, and only one CS_n bit across both ports is ever low.

## Timing
- Reset values: IOR_n=1, IOW_n=1, IDE1_CS_n=2'b11, IDE2_CS_n=2'b11, IDE_ROMEN=0, ROM_BANK=2'b00, DTACK=0, AS_n_S4=1, state IDLE.
- Reset asserted mid-cycle: all of the above apply on the next edge; no hold phase.
- All outputs are registered; no combinational path from inputs to outputs.
- IDE cycle with defaults, edge 0 = first edge with start condition true:
  - CS low after edge 0.
  - Strobe low after edge 1.
  - DTACK high after edge 2.
  - Strobe high after edge 3.
  - CS high after edge 4.
  - DTACK low one edge after AS_n_S4=1.
- Strobe width = `STROBE_CYCLES`×141 ns.
- Back-to-back cycles: a new cycle cannot start until ACK→IDLE has occurred. This guarantees ≥1 idle cycle with all CS high.
- RW and ADDR are sampled at start and held in registers for the whole cycle.

## Structure
- `ide_ctrl_pkg`:
  - state enum (IDLE, SETUP, STROBE, HOLD, ROMRD, ACK);
  - address bit constants (ROM/IDE select bit 15, port bit 14, CS bit 13, bank-write tag 3'b111);
  - default timing constants.
- One sub-module, `ide_wait_counter`: 2-bit loadable down-counter with zero flag, instantiated once.

## Test plan
- Reset with AS_n=0 and ide_access=1 held → all outputs at reset values for the whole reset; no strobe.
- IDE1 CS0 read, ADDR[15:13]=3'b100, RW=1 → IDE1_CS_n=2'b10; IOR_n low for exactly 2 cycles, starting 1 cycle after CS; DTACK on the 2nd strobe cycle; CS released 1 cycle after IOR_n.
- IDE2 CS1 write, ADDR[15:13]=3'b111, RW=0, LDS_n low → IDE2_CS_n=2'b01, IOW_n low 2 cycles; IOR_n stays 1.
- Bank write, ADDR[15:12]=4'b0111, DIN=2'b10 → ROM_BANK=2'b10 after 1 edge; following ROM read has IDE_ROMEN=1 and DTACK after 1 cycle.
- AS_n negated during the 1st STROBE cycle → IOW_n high next edge; CS held 1 more cycle; DTACK never asserted.
- `ide_enable`=0, IDE read issued → no CS, strobe, ROMEN or DTACK activity.
